// File: rtl/gat_loader_pkg.sv
// Shared types and helpers for the GAT BRAM loader: FSM states, region encoding,
// default address widths and the region-sequencing functions.
package gat_loader_pkg;

  localparam int TOP_WIDTH_DEF        = 32;
  localparam int H_DATA_ADDR_W_DEF    = 18;
  localparam int NODE_INFO_ADDR_W_DEF = 14;
  localparam int WEIGHT_ADDR_W_DEF    = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_H,
    ST_LOAD_NI,
    ST_LOAD_W,
    ST_DONE,
    ST_ERR
  } load_state_e;

  typedef enum logic [1:0] {
    REG_H  = 2'd0,
    REG_NI = 2'd1,
    REG_W  = 2'd2
  } region_e;

  // First region at or after index 'from' with a nonzero length; DONE if none remain.
  function automatic load_state_e first_load(input logic [2:0] nz, input logic [1:0] from);
    first_load = ST_DONE;
    if (nz[REG_W]  && (from <= REG_W))  first_load = ST_LOAD_W;
    if (nz[REG_NI] && (from <= REG_NI)) first_load = ST_LOAD_NI;
    if (nz[REG_H]  && (from == REG_H))  first_load = ST_LOAD_H;
  endfunction

  // Done flags implied by entering a state: every region ordered before it is complete.
  function automatic logic [2:0] done_mask(input load_state_e st);
    case (st)
      ST_LOAD_NI: done_mask = 3'b001;
      ST_LOAD_W:  done_mask = 3'b011;
      ST_DONE:    done_mask = 3'b111;
      default:    done_mask = 3'b000;
    endcase
  endfunction

  function automatic logic is_load(input load_state_e st);
    is_load = (st == ST_LOAD_H) || (st == ST_LOAD_NI) || (st == ST_LOAD_W);
  endfunction

endpackage

// File: rtl/gat_bram_wr_port.sv
// One BRAM write port: registers a one-cycle write strobe with its data and the
// byte address derived from a word index.
module gat_bram_wr_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ena,
  output logic              o_wea,
  output logic [ADDR_W+1:0] o_addra,
  output logic [DATA_W-1:0] o_din
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ena   <= 1'b0;
      o_wea   <= 1'b0;
      o_addra <= '0;
      o_din   <= '0;
    end else begin
      o_ena <= i_wr;
      o_wea <= i_wr;
      if (i_wr) begin
        o_addra <= {i_idx, 2'b00};
        o_din   <= i_data;
      end
    end
  end

endmodule

// File: rtl/gat_bram_loader.sv
// Splits one DMA word stream into the H-data, node-info and weight BRAMs in that
// order, tracking per-region done flags and tlast protocol errors.
module gat_bram_loader
  import gat_loader_pkg::*;
#(
  parameter int TOP_WIDTH        = TOP_WIDTH_DEF,
  parameter int H_DATA_ADDR_W    = H_DATA_ADDR_W_DEF,
  parameter int NODE_INFO_ADDR_W = NODE_INFO_ADDR_W_DEF,
  parameter int WEIGHT_ADDR_W    = WEIGHT_ADDR_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [H_DATA_ADDR_W:0]      h_data_len,
  input  logic [NODE_INFO_ADDR_W:0]   node_info_len,
  input  logic [WEIGHT_ADDR_W:0]      wgt_len,
  input  logic [TOP_WIDTH-1:0]        s_tdata,
  input  logic                        s_tvalid,
  input  logic                        s_tlast,
  output logic                        s_tready,
  output logic [TOP_WIDTH-1:0]        h_data_bram_din,
  output logic                        h_data_bram_ena,
  output logic                        h_data_bram_wea,
  output logic [H_DATA_ADDR_W+1:0]    h_data_bram_addra,
  output logic [TOP_WIDTH-1:0]        h_node_info_bram_din,
  output logic                        h_node_info_bram_ena,
  output logic                        h_node_info_bram_wea,
  output logic [NODE_INFO_ADDR_W+1:0] h_node_info_bram_addra,
  output logic [TOP_WIDTH-1:0]        wgt_bram_din,
  output logic                        wgt_bram_ena,
  output logic                        wgt_bram_wea,
  output logic [WEIGHT_ADDR_W+1:0]    wgt_bram_addra,
  output logic                        h_data_bram_load_done,
  output logic                        h_node_info_bram_load_done,
  output logic                        wgt_bram_load_done,
  output logic                        load_busy,
  output logic                        load_err
);

  localparam int HN_W  = (H_DATA_ADDR_W > NODE_INFO_ADDR_W) ? H_DATA_ADDR_W : NODE_INFO_ADDR_W;
  localparam int CNT_W = (HN_W > WEIGHT_ADDR_W) ? HN_W : WEIGHT_ADDR_W;

  load_state_e               r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [H_DATA_ADDR_W:0]    r_h_len;
  logic [NODE_INFO_ADDR_W:0] r_ni_len;
  logic [WEIGHT_ADDR_W:0]    r_w_len;
  logic [2:0]                r_done;
  logic [2:0]                r_pend;
  logic                      r_err;
  logic                      r_busy;

  load_state_e               w_state_nxt;
  logic [2:0]                w_pend_nxt;
  logic [2:0]                w_nz;
  logic [2:0]                w_in_nz;
  logic [1:0]                w_next_from;
  logic [CNT_W:0]            w_cur_len;
  logic [CNT_W:0]            w_cnt_inc;
  logic                      w_accept;
  logic                      w_last_word;
  logic                      w_final_word;
  logic                      w_err_set;
  logic                      w_start_ok;

  assign w_nz      = {|r_w_len, |r_ni_len, |r_h_len};
  assign w_in_nz   = {|wgt_len, |node_info_len, |h_data_len};
  assign w_accept  = s_tvalid && r_busy;
  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_pend_nxt   = 3'b000;
    w_err_set    = 1'b0;
    w_start_ok   = 1'b0;
    w_cur_len    = '0;
    w_next_from  = 2'd3;
    w_last_word  = 1'b0;
    w_final_word = 1'b0;

    case (r_state)
      ST_LOAD_H:  begin w_cur_len = (CNT_W+1)'(r_h_len);  w_next_from = REG_NI; end
      ST_LOAD_NI: begin w_cur_len = (CNT_W+1)'(r_ni_len); w_next_from = REG_W;  end
      ST_LOAD_W:  begin w_cur_len = (CNT_W+1)'(r_w_len);  w_next_from = 2'd3;   end
      default:    ;
    endcase

    w_last_word  = w_accept && (w_cnt_inc == w_cur_len);
    w_final_word = w_last_word && (first_load(w_nz, w_next_from) == ST_DONE);

    if (!is_load(r_state)) begin
      if (start) begin
        w_start_ok  = 1'b1;
        w_state_nxt = first_load(w_in_nz, REG_H);
        if (w_state_nxt == ST_DONE) w_pend_nxt = 3'b111;
      end
    end else if (w_accept) begin
      if (s_tlast && !w_final_word) begin
        w_state_nxt = ST_ERR;
        w_err_set   = 1'b1;
      end else if (w_last_word) begin
        // Entering the next region also completes any zero-length regions skipped over.
        w_state_nxt = first_load(w_nz, w_next_from);
        w_pend_nxt  = done_mask(w_state_nxt);
        w_err_set   = w_final_word && !s_tlast;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_h_len  <= '0;
      r_ni_len <= '0;
      r_w_len  <= '0;
      r_done   <= '0;
      r_pend   <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= is_load(w_state_nxt);
      r_pend  <= w_pend_nxt;
      r_done  <= r_done | r_pend;
      if (w_start_ok) begin
        r_h_len  <= h_data_len;
        r_ni_len <= node_info_len;
        r_w_len  <= wgt_len;
        r_done   <= '0;
        r_err    <= 1'b0;
        r_cnt    <= '0;
      end else begin
        if (w_err_set) r_err <= 1'b1;
        if (w_accept)  r_cnt <= w_last_word ? '0 : w_cnt_inc[CNT_W-1:0];
      end
    end
  end

  assign s_tready                   = r_busy;
  assign load_busy                  = r_busy;
  assign load_err                   = r_err;
  assign h_data_bram_load_done      = r_done[REG_H];
  assign h_node_info_bram_load_done = r_done[REG_NI];
  assign wgt_bram_load_done         = r_done[REG_W];

  gat_bram_wr_port #(.DATA_W(TOP_WIDTH), .ADDR_W(H_DATA_ADDR_W)) u_h_port (
    .clk(clk), .rst(rst),
    .i_wr(w_accept && (r_state == ST_LOAD_H)),
    .i_idx(r_cnt[H_DATA_ADDR_W-1:0]), .i_data(s_tdata),
    .o_ena(h_data_bram_ena), .o_wea(h_data_bram_wea),
    .o_addra(h_data_bram_addra), .o_din(h_data_bram_din)
  );

  gat_bram_wr_port #(.DATA_W(TOP_WIDTH), .ADDR_W(NODE_INFO_ADDR_W)) u_ni_port (
    .clk(clk), .rst(rst),
    .i_wr(w_accept && (r_state == ST_LOAD_NI)),
    .i_idx(r_cnt[NODE_INFO_ADDR_W-1:0]), .i_data(s_tdata),
    .o_ena(h_node_info_bram_ena), .o_wea(h_node_info_bram_wea),
    .o_addra(h_node_info_bram_addra), .o_din(h_node_info_bram_din)
  );

  gat_bram_wr_port #(.DATA_W(TOP_WIDTH), .ADDR_W(WEIGHT_ADDR_W)) u_w_port (
    .clk(clk), .rst(rst),
    .i_wr(w_accept && (r_state == ST_LOAD_W)),
    .i_idx(r_cnt[WEIGHT_ADDR_W-1:0]), .i_data(s_tdata),
    .o_ena(wgt_bram_ena), .o_wea(wgt_bram_wea),
    .o_addra(wgt_bram_addra), .o_din(wgt_bram_din)
  );

endmodule

// File: tb/tb_gat_bram_loader.sv
// Directed bench for gat_bram_loader: region ordering, write latency, done-flag
// timing, zero-length skipping, tlast errors and asynchronous reset.
module tb_gat_bram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [18:0] h_data_len;
  logic [14:0] node_info_len;
  logic [15:0] wgt_len;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [31:0] h_data_bram_din;
  logic        h_data_bram_ena;
  logic        h_data_bram_wea;
  logic [19:0] h_data_bram_addra;
  logic [31:0] h_node_info_bram_din;
  logic        h_node_info_bram_ena;
  logic        h_node_info_bram_wea;
  logic [15:0] h_node_info_bram_addra;
  logic [31:0] wgt_bram_din;
  logic        wgt_bram_ena;
  logic        wgt_bram_wea;
  logic [16:0] wgt_bram_addra;
  logic        h_data_bram_load_done;
  logic        h_node_info_bram_load_done;
  logic        wgt_bram_load_done;
  logic        load_busy;
  logic        load_err;

  int n_checks = 0;
  int n_fail   = 0;

  gat_bram_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .h_data_len(h_data_len), .node_info_len(node_info_len), .wgt_len(wgt_len),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .h_data_bram_din(h_data_bram_din), .h_data_bram_ena(h_data_bram_ena),
    .h_data_bram_wea(h_data_bram_wea), .h_data_bram_addra(h_data_bram_addra),
    .h_node_info_bram_din(h_node_info_bram_din), .h_node_info_bram_ena(h_node_info_bram_ena),
    .h_node_info_bram_wea(h_node_info_bram_wea), .h_node_info_bram_addra(h_node_info_bram_addra),
    .wgt_bram_din(wgt_bram_din), .wgt_bram_ena(wgt_bram_ena),
    .wgt_bram_wea(wgt_bram_wea), .wgt_bram_addra(wgt_bram_addra),
    .h_data_bram_load_done(h_data_bram_load_done),
    .h_node_info_bram_load_done(h_node_info_bram_load_done),
    .wgt_bram_load_done(wgt_bram_load_done),
    .load_busy(load_busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_done(input string tag, input logic [2:0] exp);
    check(tag, {wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}, exp);
  endtask

  // rg: 0=H, 1=NI, 2=W, -1=no write expected this cycle
  task automatic chk_wr(input int rg, input logic [31:0] d, input logic [19:0] a);
    check("h_ena",  {h_data_bram_ena, h_data_bram_wea},           (rg == 0) ? 2'b11 : 2'b00);
    check("ni_ena", {h_node_info_bram_ena, h_node_info_bram_wea}, (rg == 1) ? 2'b11 : 2'b00);
    check("w_ena",  {wgt_bram_ena, wgt_bram_wea},                 (rg == 2) ? 2'b11 : 2'b00);
    case (rg)
      0: begin check("h_addra", h_data_bram_addra, a);       check("h_din", h_data_bram_din, d);       end
      1: begin check("ni_addra", h_node_info_bram_addra, a); check("ni_din", h_node_info_bram_din, d); end
      2: begin check("w_addra", wgt_bram_addra, a);          check("w_din", wgt_bram_din, d);          end
      default: ;
    endcase
  endtask

  task automatic do_start(input logic [18:0] h, input logic [14:0] ni, input logic [15:0] w);
    h_data_len = h; node_info_len = ni; wgt_len = w;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int rg, input logic [31:0] d, input logic last, input logic [19:0] a);
    check("tready_before_beat", s_tready, 1'b1);
    s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk_wr(rg, d, a);
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_ready_busy_err"}, {s_tready, load_busy, load_err}, 3'b000);
    chk_done({tag, "_done"}, 3'b000);
    check({tag, "_enas"}, {h_data_bram_ena, h_data_bram_wea, h_node_info_bram_ena,
                           h_node_info_bram_wea, wgt_bram_ena, wgt_bram_wea}, 6'b0);
    check({tag, "_addrs"}, {h_data_bram_addra, h_node_info_bram_addra, wgt_bram_addra}, 64'd0);
    check({tag, "_dins"}, {h_data_bram_din | h_node_info_bram_din | wgt_bram_din}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    h_data_len = '0; node_info_len = '0; wgt_len = '0;
    #12;
    chk_all_zero("reset");
    #10 rst = 1'b0;
    tick();
    chk_all_zero("idle");

    // 1: lengths 4/2/3, continuous beats, tlast on the ninth
    do_start(19'd4, 15'd2, 16'd3);
    check("t1_busy", load_busy, 1'b1);
    beat(0, 32'hA000_0000, 1'b0, 20'd0);
    beat(0, 32'hA000_0001, 1'b0, 20'd4);
    beat(0, 32'hA000_0002, 1'b0, 20'd8);
    beat(0, 32'hA000_0003, 1'b0, 20'd12);
    chk_done("t1_done_after_h_strobe", 3'b000);
    beat(1, 32'hB000_0000, 1'b0, 20'd0);
    chk_done("t1_h_done", 3'b001);
    beat(1, 32'hB000_0001, 1'b0, 20'd4);
    beat(2, 32'hC000_0000, 1'b0, 20'd0);
    chk_done("t1_ni_done", 3'b011);
    beat(2, 32'hC000_0001, 1'b0, 20'd4);
    beat(2, 32'hC000_0002, 1'b1, 20'd8);
    chk_done("t1_w_not_yet", 3'b011);
    check("t1_ready_after_last", s_tready, 1'b0);
    tick();
    chk_done("t1_all_done", 3'b111);
    chk_wr(-1, 32'd0, 20'd0);
    check("t1_err", load_err, 1'b0);
    check("t1_busy_done", load_busy, 1'b0);

    // 2: lengths 3/1/1, valid toggling 1010..., start mid-load is ignored
    do_start(19'd3, 15'd1, 16'd1);
    chk_done("t2_cleared", 3'b000);
    beat(0, 32'h1111_0000, 1'b0, 20'd0);
    start = 1'b1; h_data_len = 19'd7;
    tick();
    start = 1'b0;
    chk_wr(-1, 32'd0, 20'd0);
    beat(0, 32'h1111_0001, 1'b0, 20'd4);
    tick();
    chk_wr(-1, 32'd0, 20'd0);
    beat(0, 32'h1111_0002, 1'b0, 20'd8);
    tick();
    chk_wr(-1, 32'd0, 20'd0);
    beat(1, 32'h2222_0000, 1'b0, 20'd0);
    tick();
    chk_wr(-1, 32'd0, 20'd0);
    beat(2, 32'h3333_0000, 1'b1, 20'd0);
    chk_done("t2_w_not_yet", 3'b011);
    tick();
    chk_done("t2_w_done_2cyc", 3'b111);
    check("t2_err", load_err, 1'b0);

    // 3: lengths 2/0/2, NI skipped and completes together with H
    do_start(19'd2, 15'd0, 16'd2);
    beat(0, 32'h4444_0000, 1'b0, 20'd0);
    beat(0, 32'h4444_0001, 1'b0, 20'd4);
    chk_done("t3_none_yet", 3'b000);
    beat(2, 32'h5555_0000, 1'b0, 20'd0);
    chk_done("t3_h_ni_same_cycle", 3'b011);
    beat(2, 32'h5555_0001, 1'b1, 20'd4);
    tick();
    chk_done("t3_all_done", 3'b111);

    // 4: lengths 3/1/1, tlast early on beat 2
    do_start(19'd3, 15'd1, 16'd1);
    beat(0, 32'h6666_0000, 1'b0, 20'd0);
    beat(0, 32'h6666_0001, 1'b1, 20'd4);
    check("t4_err", load_err, 1'b1);
    check("t4_ready", s_tready, 1'b0);
    s_tvalid = 1'b1; s_tdata = 32'hDEAD_BEEF;
    tick();
    s_tvalid = 1'b0;
    chk_wr(-1, 32'd0, 20'd0);
    chk_done("t4_no_done", 3'b000);
    check("t4_err_sticky", load_err, 1'b1);
    do_start(19'd1, 15'd1, 16'd1);
    check("t4_err_cleared", load_err, 1'b0);
    beat(0, 32'h7777_0000, 1'b0, 20'd0);
    beat(1, 32'h7777_0001, 1'b0, 20'd0);
    beat(2, 32'h7777_0002, 1'b0, 20'd0);
    check("t4_missing_tlast_err", load_err, 1'b1);
    tick();
    chk_done("t4_done_despite_err", 3'b111);

    // 5: lengths 0/0/0
    do_start(19'd0, 15'd0, 16'd0);
    check("t5_ready0", s_tready, 1'b0);
    chk_done("t5_cleared", 3'b000);
    tick();
    chk_done("t5_all_done", 3'b111);
    check("t5_ready1", s_tready, 1'b0);
    check("t5_err", load_err, 1'b0);

    // 6: asynchronous reset inside LOAD_NI after two accepts
    do_start(19'd1, 15'd3, 16'd1);
    beat(0, 32'h8888_0000, 1'b0, 20'd0);
    beat(1, 32'h8888_0001, 1'b0, 20'd0);
    chk_done("t6_h_done", 3'b001);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("t6_async_rst");
    #2 rst = 1'b0;
    tick();
    chk_all_zero("t6_after_rst");
    do_start(19'd1, 15'd1, 16'd1);
    beat(0, 32'h9999_0000, 1'b0, 20'd0);
    beat(1, 32'h9999_0001, 1'b0, 20'd0);
    beat(2, 32'h9999_0002, 1'b1, 20'd0);
    tick();
    chk_done("t6_reload_done", 3'b111);
    check("t6_err", load_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gat_bram_loader.md
Name: gat_bram_loader

Overview:
- Upstream feeder for the GAT accelerator top level. Accepts one 32-bit word stream from the DMA.
- Writes the stream, in a fixed order, into the H-data, H-node-info and weight BRAM write ports. The order is H-data, then node-info, then weight.
- Drives the byte-addressed BRAM port signals and the per-region load_done flags that the register bank presents to the accelerator.

Parameters:
- TOP_WIDTH, 32, stream word and BRAM din width.
- H_DATA_ADDR_W, 18, word-address width of the H-data region.
- NODE_INFO_ADDR_W, 14, word-address width of the node-info region.
- WEIGHT_ADDR_W, 15, word-address width of the weight region.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- h_data_len  in  H_DATA_ADDR_W+1  word count for H-data, sampled on start
- node_info_len  in  NODE_INFO_ADDR_W+1  word count for node-info, sampled on start
- wgt_len  in  WEIGHT_ADDR_W+1  word count for weight, sampled on start
- s_tdata  in  TOP_WIDTH  stream data
- s_tvalid  in  1  stream valid
- s_tlast  in  1  marks the last word of the whole load
- s_tready  out  1  stream ready
- h_data_bram_din  out  TOP_WIDTH
- h_data_bram_ena  out  1
- h_data_bram_wea  out  1
- h_data_bram_addra  out  H_DATA_ADDR_W+2  byte address
- h_node_info_bram_din  out  TOP_WIDTH
- h_node_info_bram_ena  out  1
- h_node_info_bram_wea  out  1
- h_node_info_bram_addra  out  NODE_INFO_ADDR_W+2  byte address
- wgt_bram_din  out  TOP_WIDTH
- wgt_bram_ena  out  1
- wgt_bram_wea  out  1
- wgt_bram_addra  out  WEIGHT_ADDR_W+2  byte address
- h_data_bram_load_done  out  1  sticky
- h_node_info_bram_load_done  out  1  sticky
- wgt_bram_load_done  out  1  sticky
- load_busy  out  1  high in any LOAD_* state
- load_err  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-load aborts immediately; no partial done flag survives.
- FSM states: IDLE, LOAD_H, LOAD_NI, LOAD_W, DONE, ERR.
- On start:
  - Latch the three lengths.
  - Clear all done flags and load_err.
  - Clear the word counter.
  - Go to the first region with nonzero length, in the order H, NI, W.
  - If all three lengths are 0, go to DONE and set all three done flags on the next cycle.
- s_tready = 1 exactly in the LOAD_* states.
- A beat is accepted when s_tvalid and s_tready are both high.
- Accepted beat at word counter k:
  - Next cycle, the active region's ena=1, wea=1, din=s_tdata, addra={k,2'b00}.
  - Write strobes are 1-cycle pulses, so latency is 1 cycle.
  - The other regions' ena/wea stay 0.
- When k = len-1 on accept:
  - Counter resets to 0.
  - FSM moves to the next region with nonzero length, skipping zero-length regions, or to DONE after weight.
  - Skipped zero-length regions get their done flag set together with the preceding region's flag.
- Done flag timing: a region's done flag rises 2 cycles after its final accept, i.e. the cycle after its final write strobe. Flags then stay high until the next start.
- tlast checking:
  - s_tlast on an accepted beat that is not the final word of the final nonzero region sets load_err. The beat is still written. FSM then goes to ERR, where tready=0 and no further done flags are set.
  - Final word accepted with s_tlast=0 sets load_err but completes normally to DONE.
- start while in a LOAD_* state is ignored.
- start while in DONE or ERR begins a new load.
- s_tvalid in IDLE, DONE or ERR is not accepted, and no write occurs.
- Address arithmetic never wraps: len is at most 2^ADDR_W, so the counter fits ADDR_W bits.
- load_busy = (state is LOAD_*), registered.

Decomposition:
- Package gat_loader_pkg holds:
  - the state enum;
  - region-select encoding (REG_H, REG_NI, REG_W);
  - default address widths shared with the accelerator top.
- One sub-module: gat_bram_wr_port, instantiated ×3, to register din/ena/wea/addra from a word index and strobe.

Test Plan:
1. Lengths 4/2/3, 9 beats with tlast on beat 9:
   - H writes at addra 0, 4, 8, 12, then NI at 0, 4, then W at 0, 4, 8, with din matching the beats.
   - Done flags rise in order; load_err=0.
2. s_tvalid toggling 1010… with lengths 3/1/1:
   - Writes occur only one cycle after accepted beats, with no gaps in addresses.
   - wgt_bram_load_done rises 2 cycles after the 5th accept.
3. Lengths 2/0/2:
   - h_data_bram_load_done and h_node_info_bram_load_done rise in the same cycle.
   - No NI write strobe occurs.
   - W writes at addra 0 and 4.
4. tlast on beat 2 of lengths 3/1/1:
   - Beat 2 is written at H addra 4; load_err=1; state ERR; s_tready=0; all done flags 0.
   - A subsequent start clears load_err.
5. Lengths 0/0/0, start pulse:
   - All three done flags are 1 on the cycle after DONE is entered.
   - s_tready is never 1.
6. rst pulse during LOAD_NI after 2 accepts:
   - All outputs 0 asynchronously.
   - A following start with 1/1/1 loads correctly from addra 0.
